// File: rtl/alarm_scheduler_if.sv
// Slot-programming bus between the clock's settings logic and the alarm scheduler.
interface alarm_scheduler_if #(
   parameter int NUM_SLOTS = 4
);
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic              wr_en;
   logic [SLOT_W-1:0] wr_slot;
   logic [4:0]        wr_hour;
   logic [5:0]        wr_min;
   logic              wr_arm;
   logic              wr_err;

   modport master (output wr_en, wr_slot, wr_hour, wr_min, wr_arm, input wr_err);
   modport slave  (input wr_en, wr_slot, wr_hour, wr_min, wr_arm, output wr_err);
endinterface

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: matches armed slots against time-of-day on each
// 1-second tick and sequences the ring / snooze / stop lifecycle.
module alarm_scheduler #(
   parameter int NUM_SLOTS       = 4,
   parameter int ALARM_DURATION  = 15,
   parameter int SNOOZE_DURATION = 30,
   parameter int MAX_SNOOZES     = 3,
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int RING_W = $clog2(ALARM_DURATION + 1),
   localparam int SNZ_W  = $clog2(SNOOZE_DURATION + 1),
   localparam int USED_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_1s,
   input  logic [4:0]           cur_hour,
   input  logic [5:0]           cur_min,
   input  logic [5:0]           cur_sec,
   input  logic                 al_on,
   input  logic                 stop,
   input  logic                 snooze,
   alarm_scheduler_if.slave     wr_bus,
   output logic                 alarm_ring,
   output logic [SLOT_W-1:0]    active_slot,
   output logic [1:0]           state,
   output logic [USED_W-1:0]    snooze_used,
   output logic [NUM_SLOTS-1:0] slot_armed
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RINGING  = 2'd1;
   localparam logic [1:0] SNOOZING = 2'd2;

   localparam logic [RING_W-1:0] RING_LOAD = RING_W'(ALARM_DURATION);
   localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_DURATION);
   localparam logic [USED_W-1:0] USED_MAX  = USED_W'(MAX_SNOOZES);

   logic [4:0]        slot_hour [NUM_SLOTS];
   logic [5:0]        slot_min  [NUM_SLOTS];
   logic [RING_W-1:0] ring_cnt, ring_cnt_next;
   logic [SNZ_W-1:0]  snz_cnt, snz_cnt_next;
   logic [USED_W-1:0] snooze_used_next;
   logic [SLOT_W-1:0] active_slot_next;
   logic [1:0]        state_next;
   logic              stop_q, snooze_q;
   logic              stop_edge, snooze_edge;
   logic              match_hit;
   logic [SLOT_W-1:0] match_idx;
   logic              wr_valid;

   assign stop_edge   = stop & ~stop_q;
   assign snooze_edge = snooze & ~snooze_q;
   assign wr_valid    = (wr_bus.wr_hour <= 5'd23) && (wr_bus.wr_min <= 6'd59)
                        && (int'(wr_bus.wr_slot) < NUM_SLOTS);

   // Descending scan so the lowest matching slot is the one left standing.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_armed[i] && slot_hour[i] == cur_hour && slot_min[i] == cur_min) begin
            match_hit = 1'b1;
            match_idx = SLOT_W'(i);
         end
      end
      match_hit = match_hit && al_on && tick_1s && (cur_sec == 6'd0);
   end

   always_comb begin
      state_next       = state;
      ring_cnt_next    = ring_cnt;
      snz_cnt_next     = snz_cnt;
      snooze_used_next = snooze_used;
      active_slot_next = active_slot;
      case (state)
         IDLE: begin
            if (match_hit) begin
               state_next       = RINGING;
               ring_cnt_next    = RING_LOAD;
               active_slot_next = match_idx;
               snooze_used_next = '0;
            end
         end
         RINGING: begin
            if (!al_on || stop_edge) begin
               state_next = IDLE;
            end else if (snooze_edge && snooze_used < USED_MAX) begin
               state_next       = SNOOZING;
               snz_cnt_next     = SNZ_LOAD;
               snooze_used_next = snooze_used + USED_W'(1);
            end else if (tick_1s) begin
               if (ring_cnt <= RING_W'(1)) state_next = IDLE;
               else                        ring_cnt_next = ring_cnt - RING_W'(1);
            end
         end
         SNOOZING: begin
            if (!al_on || stop_edge) begin
               state_next = IDLE;
            end else if (tick_1s) begin
               if (snz_cnt <= SNZ_W'(1)) begin
                  state_next    = RINGING;
                  ring_cnt_next = RING_LOAD;
               end else begin
                  snz_cnt_next = snz_cnt - SNZ_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Edge-detect registers reset high so a button held through reset is inert.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         alarm_ring  <= 1'b0;
         active_slot <= '0;
         snooze_used <= '0;
         ring_cnt    <= '0;
         snz_cnt     <= '0;
         stop_q      <= 1'b1;
         snooze_q    <= 1'b1;
      end else begin
         state       <= state_next;
         alarm_ring  <= (state_next == RINGING);
         active_slot <= active_slot_next;
         snooze_used <= snooze_used_next;
         ring_cnt    <= ring_cnt_next;
         snz_cnt     <= snz_cnt_next;
         stop_q      <= stop;
         snooze_q    <= snooze;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_bus.wr_err <= 1'b0;
         slot_armed    <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hour[i] <= '0;
            slot_min[i]  <= '0;
         end
      end else begin
         wr_bus.wr_err <= wr_bus.wr_en && !wr_valid;
         if (wr_bus.wr_en && wr_valid) begin
            slot_hour[wr_bus.wr_slot]  <= wr_bus.wr_hour;
            slot_min[wr_bus.wr_slot]   <= wr_bus.wr_min;
            slot_armed[wr_bus.wr_slot] <= wr_bus.wr_arm;
         end
      end
   end
endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler with hand-computed expectations.
module tb_alarm_scheduler;
   logic       clk;
   logic       reset;
   logic       tick_1s;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic       al_on;
   logic       stop;
   logic       snooze;
   logic       alarm_ring;
   logic [1:0] active_slot;
   logic [1:0] state;
   logic [1:0] snooze_used;
   logic [3:0] slot_armed;

   int checks;
   int passes;
   logic saw_ring;

   alarm_scheduler_if #(.NUM_SLOTS(4)) bus ();

   alarm_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .tick_1s     (tick_1s),
      .cur_hour    (cur_hour),
      .cur_min     (cur_min),
      .cur_sec     (cur_sec),
      .al_on       (al_on),
      .stop        (stop),
      .snooze      (snooze),
      .wr_bus      (bus.slave),
      .alarm_ring  (alarm_ring),
      .active_slot (active_slot),
      .state       (state),
      .snooze_used (snooze_used),
      .slot_armed  (slot_armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic writeSlot(input int slot, input int h, input int m, input logic arm);
      bus.wr_slot = 2'(slot);
      bus.wr_hour = 5'(h);
      bus.wr_min  = 6'(m);
      bus.wr_arm  = arm;
      bus.wr_en   = 1'b1;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic doTick(input int h, input int m, input int s);
      step();
      cur_hour = 5'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
      tick_1s  = 1'b1;
      step();
      tick_1s  = 1'b0;
   endtask

   task automatic applyStimulus();
      // Reset values
      reset = 1'b0; tick_1s = 1'b0; cur_hour = '0; cur_min = '0; cur_sec = '0;
      al_on = 1'b1; stop = 1'b0; snooze = 1'b0;
      bus.wr_en = 1'b0; bus.wr_slot = '0; bus.wr_hour = '0; bus.wr_min = '0; bus.wr_arm = 1'b0;
      repeat (3) step();
      checkOutput("rst_state", 32'(state), 0);
      checkOutput("rst_ring", 32'(alarm_ring), 0);
      checkOutput("rst_armed", 32'(slot_armed), 0);
      checkOutput("rst_err", 32'(bus.wr_err), 0);
      checkOutput("rst_used", 32'(snooze_used), 0);
      checkOutput("rst_active", 32'(active_slot), 0);
      reset = 1'b1;
      step();

      // Match and timeout
      writeSlot(2, 6, 30, 1'b1);
      checkOutput("wr_ok_err", 32'(bus.wr_err), 0);
      checkOutput("wr_ok_armed", 32'(slot_armed), 32'h4);
      doTick(6, 29, 59);
      checkOutput("pre_match_ring", 32'(alarm_ring), 0);
      doTick(6, 30, 0);
      checkOutput("match_ring", 32'(alarm_ring), 1);
      checkOutput("match_state", 32'(state), 1);
      checkOutput("match_active", 32'(active_slot), 2);
      for (int s = 1; s <= 14; s++) doTick(6, 30, s);
      checkOutput("ring_tick14", 32'(alarm_ring), 1);
      doTick(6, 30, 15);
      checkOutput("timeout_ring", 32'(alarm_ring), 0);
      checkOutput("timeout_state", 32'(state), 0);
      saw_ring = 1'b0;
      for (int s = 16; s <= 59; s++) begin
         doTick(6, 30, s);
         saw_ring |= alarm_ring;
      end
      checkOutput("no_retrigger", 32'(saw_ring), 0);

      // Priority
      writeSlot(1, 7, 0, 1'b1);
      writeSlot(3, 7, 0, 1'b1);
      doTick(7, 0, 0);
      checkOutput("prio_low", 32'(active_slot), 1);
      stop = 1'b1; step();
      checkOutput("prio_stop", 32'(state), 0);
      stop = 1'b0; step();
      writeSlot(1, 7, 0, 1'b0);
      checkOutput("disarm_armed", 32'(slot_armed), 32'hC);
      doTick(7, 0, 0);
      checkOutput("prio_next", 32'(active_slot), 3);

      // Snooze cycle, three allowed
      for (int k = 1; k <= 3; k++) begin
         snooze = 1'b1; step();
         checkOutput("snz_state", 32'(state), 2);
         checkOutput("snz_ring", 32'(alarm_ring), 0);
         checkOutput("snz_used", 32'(snooze_used), 32'(k));
         snooze = 1'b0;
         for (int t = 0; t < 29; t++) doTick(7, 2, 0);
         checkOutput("snz_tick29", 32'(state), 2);
         doTick(7, 2, 0);
         checkOutput("snz_end_state", 32'(state), 1);
         checkOutput("snz_end_ring", 32'(alarm_ring), 1);
      end
      snooze = 1'b1; step();
      checkOutput("snz4_state", 32'(state), 1);
      checkOutput("snz4_used", 32'(snooze_used), 3);
      checkOutput("snz4_ring", 32'(alarm_ring), 1);
      snooze = 1'b0;
      stop = 1'b1; step();
      stop = 1'b0; step();

      // Stop precedence over snooze
      doTick(7, 0, 0);
      checkOutput("ev2_used", 32'(snooze_used), 0);
      stop = 1'b1; snooze = 1'b1; step();
      checkOutput("both_state", 32'(state), 0);
      checkOutput("both_used", 32'(snooze_used), 0);
      checkOutput("both_ring", 32'(alarm_ring), 0);
      stop = 1'b0; snooze = 1'b0; step();

      // Stop while snoozing
      doTick(7, 0, 0);
      snooze = 1'b1; step();
      snooze = 1'b0;
      checkOutput("snz2_state", 32'(state), 2);
      step();
      stop = 1'b1; step();
      checkOutput("stop_snz_state", 32'(state), 0);
      stop = 1'b0;
      saw_ring = 1'b0;
      for (int t = 0; t < 35; t++) begin
         doTick(7, 3, 0);
         saw_ring |= alarm_ring;
      end
      checkOutput("stop_snz_noring", 32'(saw_ring), 0);

      // Write validation
      writeSlot(0, 8, 15, 1'b1);
      checkOutput("slot0_armed", 32'(slot_armed), 32'hD);
      writeSlot(0, 24, 20, 1'b0);
      checkOutput("bad_hour_err", 32'(bus.wr_err), 1);
      checkOutput("bad_hour_armed", 32'(slot_armed), 32'hD);
      step();
      checkOutput("err_one_cycle", 32'(bus.wr_err), 0);
      writeSlot(0, 9, 60, 1'b0);
      checkOutput("bad_min_err", 32'(bus.wr_err), 1);
      checkOutput("bad_min_armed", 32'(slot_armed), 32'hD);
      doTick(8, 15, 0);
      checkOutput("slot0_kept_ring", 32'(alarm_ring), 1);
      checkOutput("slot0_active", 32'(active_slot), 0);
      writeSlot(0, 10, 0, 1'b1);
      checkOutput("wr_ring_ring", 32'(alarm_ring), 1);
      checkOutput("wr_ring_state", 32'(state), 1);
      checkOutput("wr_ring_err", 32'(bus.wr_err), 0);
      stop = 1'b1; step();
      stop = 1'b0; step();
      checkOutput("wr_ring_stop", 32'(state), 0);

      // al_on gating
      al_on = 1'b0;
      doTick(10, 0, 0);
      checkOutput("alon_off_ring", 32'(alarm_ring), 0);
      checkOutput("alon_off_state", 32'(state), 0);
      al_on = 1'b1;
      doTick(10, 0, 0);
      checkOutput("alon_match", 32'(alarm_ring), 1);
      snooze = 1'b1; step();
      snooze = 1'b0; step();
      checkOutput("alon_snz", 32'(state), 2);
      al_on = 1'b0; step();
      checkOutput("alon_drop_state", 32'(state), 0);
      checkOutput("alon_drop_ring", 32'(alarm_ring), 0);
      al_on = 1'b1;

      // Asynchronous reset mid-ring
      doTick(10, 0, 0);
      checkOutput("pre_rst_ring", 32'(alarm_ring), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_ring", 32'(alarm_ring), 0);
      checkOutput("async_rst_armed", 32'(slot_armed), 0);
      checkOutput("async_rst_state", 32'(state), 0);
      snooze = 1'b1; stop = 1'b1;
      step();
      #3 reset = 1'b1;
      step();
      writeSlot(0, 11, 0, 1'b1);
      checkOutput("post_rst_armed", 32'(slot_armed), 1);
      doTick(11, 0, 0);
      checkOutput("held_ring_state", 32'(state), 1);
      step();
      checkOutput("held_no_action", 32'(state), 1);
      snooze = 1'b0; stop = 1'b0; step();
      snooze = 1'b1; step();
      checkOutput("fresh_snz_edge", 32'(state), 2);
      snooze = 1'b0; step();
   endtask

   initial begin
      checks = 0;
      passes = 0;
      applyStimulus();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
